field_mul_arbiter: RTL and testbench

//  Round-robin arbiter sharing one multi-cycle field_multiplier among NREQ

---
 rtl/field_mul_arbiter.sv | 150 +++++++++++++++
 tb/tb_field_mul_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/field_mul_arbiter.sv
// field_mul_arbiter
//   Round-robin arbiter that shares one multi-cycle field multiplier among
//   NREQ requesters. The winner's operands are latched in IDLE and the
//   multiplier en/ready handshake is sequenced. The product is then returned
//   in c, with a one-cycle done pulse to the granted requester.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   req[NREQ]       per-requester request level (sampled only in IDLE)
//   op_a, op_b      per-requester operands, F_NBITS each
//   gnt[NREQ]       one-hot grant, high from ISSUE through DONE
//   done[NREQ]      one-hot, one-cycle result-valid pulse (DONE state)
//   c               registered product, held until the next DONE
//   busy            high in any state other than IDLE
//   mul_en          multiplier start pulse (ISSUE state)
//   mul_a, mul_b    latched operands presented to the multiplier
//   mul_ready       multiplier ready level
//   mul_c           multiplier product
//
// Multiplier handshake: mul_en is a single-cycle start strobe that carries
// the operands on mul_a/mul_b. Those operands stay stable until the
// operation completes. mul_ready is ignored in the ISSUE cycle. From WAIT on,
// the first cycle with mul_ready=1 is the cycle in which mul_c is valid, and
// the product is captured on that edge.

module field_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int F_NBITS = 61,
  parameter int IDX_W   = $clog2(NREQ)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NREQ-1:0]                  req,
  input  logic [NREQ-1:0][F_NBITS-1:0]     op_a,
  input  logic [NREQ-1:0][F_NBITS-1:0]     op_b,
  output logic [NREQ-1:0]                  gnt,
  output logic [NREQ-1:0]                  done,
  output logic [F_NBITS-1:0]               c,
  output logic                             busy,
  output logic                             mul_en,
  output logic [F_NBITS-1:0]               mul_a,
  output logic [F_NBITS-1:0]               mul_b,
  input  logic                             mul_ready,
  input  logic [F_NBITS-1:0]               mul_c
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [F_NBITS-1:0]   a_q, b_q, c_q;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     cand_idx;
  logic [NREQ-1:0]      idx_onehot;

  // Round-robin scan starting one past the last winner. The last candidate
  // checked is ptr itself, so a lone requester can be re-granted.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand_idx = IDX_W'((int'(ptr_q) + i) % NREQ);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign idx_onehot = NREQ'(1) << idx_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = win_found ? ISSUE : IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = mul_ready ? DONE : WAIT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    gnt    = '0;
    done   = '0;
    mul_en = 1'b0;
    busy   = 1'b0;
    case (state_q)
      ISSUE: begin
        gnt    = idx_onehot;
        mul_en = 1'b1;
        busy   = 1'b1;
      end
      WAIT: begin
        gnt  = idx_onehot;
        busy = 1'b1;
      end
      DONE: begin
        gnt  = idx_onehot;
        done = idx_onehot;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: operands are captured only when leaving IDLE, so later changes
  // on op_a/op_b cannot reach the multiplier mid-operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      ptr_q <= IDX_W'(NREQ - 1);
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
    end else begin
      if (state_q == IDLE && win_found) begin
        idx_q <= win_idx;
        ptr_q <= win_idx;
        a_q   <= op_a[win_idx];
        b_q   <= op_b[win_idx];
      end
      if (state_q == WAIT && mul_ready) begin
        c_q <= mul_c;
      end
    end
  end

  assign mul_a = a_q;
  assign mul_b = b_q;
  assign c     = c_q;

endmodule

// File: tb/tb_field_mul_arbiter.sv
module tb_field_mul_arbiter;

  localparam int NREQ = 4;
  localparam int FW   = 61;
  localparam logic [FW-1:0] P = {FW{1'b1}};  // 2^61 - 1

  logic                    clk;
  logic                    rst;
  logic [NREQ-1:0]         req;
  logic [NREQ-1:0][FW-1:0] op_a, op_b;
  logic [NREQ-1:0]         gnt, done;
  logic [FW-1:0]           c, mul_a, mul_b, mul_c;
  logic                    busy, mul_en, mul_ready;

  int n_tests = 0;
  int n_fail  = 0;
  int mul_lat = 2;

  field_mul_arbiter #(.NREQ(NREQ), .F_NBITS(FW)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .done(done), .c(c), .busy(busy), .mul_en(mul_en),
    .mul_a(mul_a), .mul_b(mul_b), .mul_ready(mul_ready), .mul_c(mul_c)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: product mod p, ready L cycles after the en cycle.
  logic [FW-1:0] m_prod;
  logic          m_pend;
  int            m_cnt;

  function automatic logic [FW-1:0] mulmod(input logic [FW-1:0] a, input logic [FW-1:0] b);
    logic [127:0] t;
    t = {67'd0, a} * {67'd0, b};
    return FW'(t % {67'd0, P});
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend <= 1'b0;
      m_cnt  <= 0;
      m_prod <= '0;
    end else if (mul_en) begin
      m_pend <= 1'b1;
      m_cnt  <= mul_lat - 1;
      m_prod <= mulmod(mul_a, mul_b);
    end else if (m_pend) begin
      if (m_cnt > 0) m_cnt <= m_cnt - 1;
      else           m_pend <= 1'b0;
    end
  end

  assign mul_ready = m_pend && (m_cnt == 0);
  assign mul_c     = mul_ready ? m_prod : (m_prod ^ FW'(61'h5A5A));

  // Driver / checker tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_issue(input string tag);
    int k;
    k = 0;
    while (mul_en !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_issue_seen"}, 64'(mul_en), 64'd1);
  endtask

  task automatic wait_done(input string tag, output int k);
    k = 0;
    while (done === '0 && k < 40) begin
      tick();
      k++;
    end
    check({tag, "_done_seen"}, 64'(done != '0), 64'd1);
  endtask

  // Full operation: grant, latency, result, then IDLE bubble.
  task automatic do_op(input string tag, input logic [NREQ-1:0] exp_g,
                       input logic [FW-1:0] exp_c, input logic [NREQ-1:0] next_req);
    int k;
    wait_issue(tag);
    check({tag, "_gnt"}, 64'(gnt), 64'(exp_g));
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(tag, k);
    check({tag, "_lat"}, 64'(k), 64'(mul_lat + 1));
    check({tag, "_done"}, 64'(done), 64'(exp_g));
    check({tag, "_c"}, 64'(c), 64'(exp_c));
    req = next_req;
    tick();
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check({tag, "_idle_done"}, 64'(done), 64'd0);
    check({tag, "_idle_gnt"}, 64'(gnt), 64'd0);
    check({tag, "_c_held"}, 64'(c), 64'(exp_c));
  endtask

  // Invariants: gnt one-hot or zero; done only alongside a matching grant.
  always @(negedge clk) begin
    check("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
    if (done != '0) check("done_eq_gnt", 64'(done), 64'(gnt));
  end

  // Directed steps
  initial begin
    int k;
    rst  = 1'b1;
    req  = '0;
    op_a = '0;
    op_b = '0;
    #1;
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mul_en", 64'(mul_en), 64'd0);
    check("rst_c", 64'(c), 64'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 1: single requester 1, 3*5
    op_a[1] = 61'd3;
    op_b[1] = 61'd5;
    req     = 4'b0010;
    tick();
    check("t1_mul_en", 64'(mul_en), 64'd1);
    check("t1_mul_a", 64'(mul_a), 64'd3);
    check("t1_mul_b", 64'(mul_b), 64'd5);
    do_op("t1", 4'b0010, 61'd15, 4'b0000);

    // 2: all requesting from reset -> 0,1,2,3,0
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = FW'(i + 2);
      op_b[i] = 61'd7;
    end
    req = 4'b1111;
    do_op("t2_g0", 4'b0001, 61'd14, 4'b1111);
    do_op("t2_g1", 4'b0010, 61'd21, 4'b1111);
    do_op("t2_g2", 4'b0100, 61'd28, 4'b1111);
    do_op("t2_g3", 4'b1000, 61'd35, 4'b1111);
    do_op("t2_g0b", 4'b0001, 61'd14, 4'b0000);

    // 3: serve 2, then 0101 -> 0 then 2
    req = 4'b0100;
    do_op("t3_g2", 4'b0100, 61'd28, 4'b0101);
    do_op("t3_g0", 4'b0001, 61'd14, 4'b0101);
    do_op("t3_g2b", 4'b0100, 61'd28, 4'b0000);

    // 4: (p-1)*(p-1) = 1; op_a change during WAIT has no effect
    mul_lat = 4;
    op_a[0] = P - 1;
    op_b[0] = P - 1;
    req     = 4'b0001;
    wait_issue("t4");
    check("t4_gnt", 64'(gnt), 64'd1);
    req = 4'b0000;
    tick();
    op_a[0] = 61'd123;
    k = 0;
    while (done === '0 && k < 40) begin
      check("t4_mul_a_stable", 64'(mul_a), 64'(P - 1));
      tick();
      k++;
    end
    check("t4_done", 64'(done), 64'd1);
    check("t4_c", 64'(c), 64'd1);
    check("t4_mul_a_done", 64'(mul_a), 64'(P - 1));
    check("t4_mul_b_done", 64'(mul_b), 64'(P - 1));
    tick();
    check("t4_idle_busy", 64'(busy), 64'd0);

    // 5: reset mid-WAIT, then pointer restarts at NREQ-1
    req = 4'b0010;
    wait_issue("t5");
    check("t5_gnt", 64'(gnt), 64'b0010);
    req = 4'b0000;
    tick();
    check("t5_in_wait", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_gnt", 64'(gnt), 64'd0);
    check("t5_rst_done", 64'(done), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_mul_en", 64'(mul_en), 64'd0);
    check("t5_rst_c", 64'(c), 64'd0);
    check("t5_rst_mul_a", 64'(mul_a), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("t5_no_done", 64'(done), 64'd0);
    req = 4'b1010;
    do_op("t5_g1", 4'b0010, 61'd21, 4'b1000);
    do_op("t5_g3", 4'b1000, 61'd35, 4'b0000);

    // 6: req[1] dropped during WAIT -> done still pulses, no re-grant
    req = 4'b0010;
    wait_issue("t6");
    tick();
    req = 4'b0000;
    wait_done("t6", k);
    check("t6_done", 64'(done), 64'b0010);
    check("t6_c", 64'(c), 64'd21);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_regrant", 64'(gnt), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
